// File: rtl/sha256_ctrl_fsm.sv
// SHA-256 sequencing controller: top-level state, round counter
// and remaining-block counter feeding the control-output decoder.
module sha256_ctrl_fsm #(
   parameter int BLK_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             pad_done,
   input  logic [BLK_W-1:0] blocks_num,
   output logic [3:0]       state,
   output logic [5:0]       round_idx,
   output logic [BLK_W-1:0] blocks_left,
   output logic             round_last
);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_PAD   = 4'd1,
      S_LOAD  = 4'd2,
      S_LENLO = 4'd3,
      S_LENHI = 4'd4,
      S_INIT  = 4'd5,
      S_PREP  = 4'd6,
      S_RND   = 4'd7,
      S_UPD   = 4'd8,
      S_DONE  = 4'd9
   } state_t;

   state_t           st_q, st_d;
   logic [5:0]       rnd_q, rnd_d;
   logic [BLK_W-1:0] left_q, left_d;
   logic [BLK_W-1:0] num_q, num_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q   <= S_IDLE;
         rnd_q  <= '0;
         left_q <= '0;
         num_q  <= '0;
      end else begin
         st_q   <= st_d;
         rnd_q  <= rnd_d;
         left_q <= left_d;
         num_q  <= num_d;
      end
   end

   always_comb begin
      st_d   = st_q;
      rnd_d  = rnd_q;
      left_d = left_q;
      num_d  = num_q;
      if (abort) begin
         st_d   = S_IDLE;
         rnd_d  = '0;
         left_d = '0;
      end else begin
         case (st_q)
            S_IDLE:  if (start) st_d = S_PAD;
            S_PAD: begin
               if (pad_done) begin
                  st_d  = S_LOAD;
                  num_d = blocks_num;
               end
            end
            S_LOAD: begin
               left_d = num_q;
               st_d   = S_LENLO;
            end
            S_LENLO: st_d = S_LENHI;
            S_LENHI: st_d = S_INIT;
            S_INIT:  st_d = (left_q == '0) ? S_DONE : S_PREP;
            S_PREP: begin
               rnd_d = '0;
               st_d  = S_RND;
            end
            // 6-bit counter wraps 63 -> 0 as the block finishes
            S_RND: begin
               rnd_d = rnd_q + 6'd1;
               if (rnd_q == 6'd63) st_d = S_UPD;
            end
            S_UPD: begin
               left_d = left_q - 1'b1;
               st_d   = (left_q == BLK_W'(1)) ? S_DONE : S_PREP;
            end
            S_DONE:  if (!start) st_d = S_IDLE;
            default: begin
               st_d   = S_IDLE;
               rnd_d  = '0;
               left_d = '0;
            end
         endcase
      end
   end

   assign state       = st_q;
   assign round_idx   = rnd_q;
   assign blocks_left = left_q;
   assign round_last  = (st_q == S_RND) && (rnd_q == 6'd63);

endmodule

// File: tb/tb_sha256_ctrl_fsm.sv
// Directed self-checking bench for sha256_ctrl_fsm.
module tb_sha256_ctrl_fsm;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic       pad_done;
   logic [7:0] blocks_num;
   logic [3:0] state;
   logic [5:0] round_idx;
   logic [7:0] blocks_left;
   logic       round_last;

   int vectors;
   int miscompares;

   sha256_ctrl_fsm #(.BLK_W(8)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .abort(abort),
      .pad_done(pad_done),
      .blocks_num(blocks_num),
      .state(state),
      .round_idx(round_idx),
      .blocks_left(blocks_left),
      .round_last(round_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue pad_done with nb blocks from PAD and follow the message to DONE.
   task automatic run_msg(input int nb, input int lat);
      int cnt, r, c6, c7, c8;
      cnt = 0; r = 0; c6 = 0; c7 = 0; c8 = 0;
      pad_done   = 1'b1;
      blocks_num = 8'(nb);
      do begin
         tick();
         cnt++;
         if (cnt == 1) begin
            pad_done   = 1'b0;
            blocks_num = 8'hff;
         end
         if (cnt <= 4) chk("setup_seq", 32'(state), 32'(cnt + 1));
         if (state == 4'd6) begin
            c6++;
            r = 0;
         end
         if (state == 4'd7) begin
            c7++;
            chk("round_idx", 32'(round_idx), 32'(r));
            chk("round_last", 32'(round_last), 32'(r == 63));
            chk("left_rnd", 32'(blocks_left), 32'(nb - c8));
            r++;
         end
         if (state == 4'd8) begin
            chk("rnd_wrap", 32'(round_idx), 32'd0);
            chk("rl_upd", 32'(round_last), 32'd0);
            chk("left_upd", 32'(blocks_left), 32'(nb - c8));
            c8++;
         end
      end while (state != 4'd9 && cnt < lat + 20);
      chk("latency", 32'(cnt), 32'(lat));
      chk("n_prep", 32'(c6), 32'(nb));
      chk("n_rounds", 32'(c7), 32'(64 * nb));
      chk("n_update", 32'(c8), 32'(nb));
      chk("left_done", 32'(blocks_left), 32'd0);
   endtask

   initial begin
      int n;
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      start       = 1'b0;
      abort       = 1'b0;
      pad_done    = 1'b0;
      blocks_num  = '0;
      #2;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_round", 32'(round_idx), 32'd0);
      chk("rst_left", 32'(blocks_left), 32'd0);
      chk("rst_rl", 32'(round_last), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) tick();
      chk("idle_hold", 32'(state), 32'd0);

      // single block
      start = 1'b1;
      tick();
      chk("start_lat", 32'(state), 32'd1);
      repeat (4) tick();
      chk("pad_wait", 32'(state), 32'd1);
      run_msg(1, 71);

      // DONE handshake
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("done_hold", 32'(state), 32'd9);
      end
      start = 1'b0;
      tick();
      chk("done_rel", 32'(state), 32'd0);
      start = 1'b1;
      tick();
      chk("retrig", 32'(state), 32'd1);

      // three blocks
      run_msg(3, 203);

      // zero blocks
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      chk("start_z", 32'(state), 32'd1);
      run_msg(0, 5);

      // abort in round 10 of block 2 of 4
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      pad_done   = 1'b1;
      blocks_num = 8'd4;
      tick();
      pad_done = 1'b0;
      n = 0;
      while (!(state == 4'd7 && round_idx == 6'd10 &&
               blocks_left == 8'd3) && n < 500) begin
         tick();
         n++;
      end
      chk("abort_reach", 32'(n < 500), 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_state", 32'(state), 32'd0);
      chk("abort_round", 32'(round_idx), 32'd0);
      chk("abort_left", 32'(blocks_left), 32'd0);

      // abort with start in IDLE, then abort with pad_done in PAD
      abort = 1'b1;
      tick();
      chk("abort_idle", 32'(state), 32'd0);
      abort = 1'b0;
      tick();
      chk("abort_idle2", 32'(state), 32'd1);
      abort      = 1'b1;
      pad_done   = 1'b1;
      blocks_num = 8'd5;
      tick();
      abort    = 1'b0;
      pad_done = 1'b0;
      chk("abort_pad", 32'(state), 32'd0);
      chk("abort_pad_l", 32'(blocks_left), 32'd0);

      // async reset mid-rounds: round 37, 3 blocks left
      tick();
      chk("restart", 32'(state), 32'd1);
      pad_done   = 1'b1;
      blocks_num = 8'd3;
      tick();
      pad_done = 1'b0;
      n = 0;
      while (!(state == 4'd7 && round_idx == 6'd37) && n < 500) begin
         tick();
         n++;
      end
      chk("rst_reach", 32'(n < 500), 32'd1);
      chk("rst_pre_l", 32'(blocks_left), 32'd3);
      rst_n = 1'b0;
      #2;
      chk("arst_state", 32'(state), 32'd0);
      chk("arst_round", 32'(round_idx), 32'd0);
      chk("arst_left", 32'(blocks_left), 32'd0);
      chk("arst_rl", 32'(round_last), 32'd0);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) tick();
      chk("post_rst", 32'(state), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sha256_ctrl_fsm.md
# sha256_ctrl_fsm

Sequencing controller for the SHA-256 datapath. It holds the top-level state register, the 64-round counter and the remaining-block counter. It emits the 4-bit state code that the control-output decoder turns into padding, length-select, hash-load, core-enable and done strobes. It sits between the host handshake (`start`/`done` level protocol) and the decoder, and is clocked with the padding unit and compression core.

## Interface
Parameters:
- `BLK_W`, default 8: width of the block-count input and counter (max 2^BLK_W−1 blocks).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level request from host; sampled in IDLE and DONE.
- `abort`  in  1  synchronous soft clear; forces IDLE on the next edge.
- `pad_done`  in  1  padding unit finished; `blocks_num` valid in the same cycle.
- `blocks_num`  in  BLK_W  number of 512-bit blocks produced by padding.
- `state`  out  4  encoded state, registered; codes listed below.
- `round_idx`  out  6  current compression round, 0..63, registered.
- `blocks_left`  out  BLK_W  blocks still to compress, including the current one.
- `round_last`  out  1  combinational: `state==7 && round_idx==63`.

Reset value of every output: `state=0`, `round_idx=0`, `blocks_left=0`, `round_last=0`.

## Operation
State codes and transitions (evaluated each rising edge; `abort` has priority over everything except reset):
- 0 IDLE: `start=1` → 1; else stay.
- 1 PAD: `pad_done=1` → 2; else stay. No timeout.
- 2 LOAD_NUM: `blocks_left <= blocks_num` (value registered in state 1 on the `pad_done` cycle) → 3.
- 3 LEN_LO: one cycle → 4.
- 4 LEN_HI: one cycle → 5.
- 5 INIT_HASH: if `blocks_left==0` → 9; else → 6.
- 6 BLK_PREP: `round_idx <= 0` → 7.
- 7 ROUNDS: `round_idx` increments each cycle. When `round_idx==63`, `round_idx` wraps to 0 and the state goes → 8.
- 8 UPDATE: `blocks_left <= blocks_left − 1`. If `blocks_left==1` → 9; else → 6.
- 9 DONE: held while `start=1`; `start=0` → 0.
- Codes 10–15 are unreachable. If one is entered (SEU, X), the next edge returns to 0 with counters cleared.
- `abort=1` in any state: next state 0, `round_idx=0`, `blocks_left=0`.
- `blocks_num` is captured into an internal register on the `pad_done` cycle in state 1. It is ignored at all other times.
- `round_idx` changes only in states 6 and 7, and holds elsewhere.
- `blocks_left` changes only in states 2 and 8, plus clears on abort or illegal state.
- No arithmetic overflow is possible:
  - The decrement happens only when `blocks_left ≥ 1`.
  - The round counter wraps modulo 64 by width.

## Timing
- All outputs are registered except `round_last`.
- Start latency: `start` sampled high in IDLE at edge k gives `state=1` after edge k.
- Setup latency: `pad_done` sampled at edge p gives state 2,3,4,5 on cycles p+1..p+4.
- Per block: 66 cycles, made up of 1× state 6, 64× state 7, and 1× state 8.
- N blocks (N≥1): `state=9` first appears after edge p+4+66N+1.
- N=0: `state=9` after edge p+5.
- Re-trigger rule: if `start` is held high through DONE, the FSM stays in 9. The host must drop `start` for at least one cycle, giving 9→0, then raise it again to begin a new message.
- Simultaneous events:
  - `abort` with `start` in IDLE: stays 0.
  - `abort` with `pad_done` in PAD: goes 0, and `blocks_num` is not captured.
- Reset mid-operation: `rst_n` low immediately forces all outputs to their reset values, independent of `clk`. The first edge after release evaluates from IDLE.

## Test plan
- Reset: assert `rst_n=0` mid-ROUNDS with `round_idx=37` and `blocks_left=3` → outputs go 0/0/0 without a clock edge. After release with `start=0`, `state` stays 0.
- Single block: `start=1`, `pad_done` after 5 cycles with `blocks_num=1` → sequence 1,2,3,4,5,6, then 64 cycles of 7 with `round_idx` 0..63 and `round_last` high only at 63, then 8, then 9. 9 is first seen 71 cycles after the `pad_done` edge.
- Multi-block: `blocks_num=3` → three 6/7×64/8 passes with `blocks_left` reading 3,2,1 during each ROUNDS. `state=9` appears 203 cycles after `pad_done`; `blocks_left=0` in DONE.
- Zero blocks: `blocks_num=0` → 2,3,4,5 then 9 with no visit to 6/7/8.
- Abort: `abort=1` at `round_idx=10` of block 2 of 4 → next cycle `state=0`, `round_idx=0`, `blocks_left=0`. Abort simultaneous with `pad_done` → `state=0` and no capture.
- DONE handshake: hold `start=1` for 20 cycles in DONE → stays 9. Drop `start` for 1 cycle → 0. Raise `start` → 1 on the next edge.
